// File: rtl/uart_resp_pkg.sv
// Shared definitions for the UART response transmitter.
// Holds the TX state encoding, the response record layout and the helpers
// that map a record onto the bytes and line levels of a UART frame.
package uart_resp_pkg;

    localparam int REC_W       = 42;
    localparam int FRAME_BYTES = 7;
    localparam int MEMTYPE_BIT = 41;
    localparam int ADDR_MSB    = 40;
    localparam int ADDR_LSB    = 32;

    typedef logic [REC_W-1:0] resp_rec_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Byte idx of the frame built from rec: header, {mem_type, 0, addr[8]},
    // addr[7:0], then the data word big-endian.
    function automatic logic [7:0] frame_byte(input resp_rec_t rec,
                                              input logic [2:0] idx,
                                              input logic [7:0] hdr);
        logic [7:0] b;
        b = hdr;
        case (idx)
            3'd0:    b = hdr;
            3'd1:    b = {rec[MEMTYPE_BIT], 6'b0, rec[ADDR_MSB]};
            3'd2:    b = rec[ADDR_MSB-1:ADDR_LSB];
            3'd3:    b = rec[31:24];
            3'd4:    b = rec[23:16];
            3'd5:    b = rec[15:8];
            3'd6:    b = rec[7:0];
            default: b = hdr;
        endcase
        return b;
    endfunction

    // Serial line level for a given position within the frame.
    function automatic logic line_level(input tx_state_t  state,
                                        input resp_rec_t  rec,
                                        input logic [2:0] byte_idx,
                                        input logic [2:0] bit_idx,
                                        input logic [7:0] hdr);
        logic [7:0] cur;
        logic       lvl;
        cur = frame_byte(rec, byte_idx, hdr);
        case (state)
            START:   lvl = 1'b0;
            DATA:    lvl = cur[bit_idx];
            default: lvl = 1'b1;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/uart_resp_fifo.sv
// Synchronous FIFO for response records.
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   push, wr_data     write request and record; a push while full is accepted
//                     only when a pop happens in the same cycle
//   pop, rd_data      read request and head record (rd_data is the current head)
//   full, empty       occupancy flags
//   count             number of stored records
module uart_resp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 42
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop frees the slot this cycle, so a push on a full FIFO still fits.
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    // NOTE: storage carries no reset; only pointers and count define validity,
    // and leaving the array unreset lets it map onto plain RAM/registers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (do_pop && !do_push) count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_response_tx.sv
// UART transmitter for memory read-back responses.
// Each 42-bit record {mem_type, addr[8:0], data[31:0]} presented with a
// one-cycle tx_data_ready pulse is queued, then sent as a 7-byte 8N1 frame:
// A5-style header, {mem_type, 6'b0, addr[8]}, addr[7:0], data big-endian.
// Ports:
//   clk, reset     clock and asynchronous active-high reset
//   tx_data_in     response record, valid with tx_data_ready
//   tx_data_ready  one-cycle capture pulse
//   uart_tx        serial line, idle high (registered)
//   tx_busy        frame in progress or records still queued
//   overflow       sticky: a record was dropped on a full FIFO
//   fifo_count     records currently queued
module uart_response_tx
    import uart_resp_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [7:0] FRAME_HDR    = 8'hA5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [REC_W-1:0]              tx_data_in,
    input  logic                          tx_data_ready,
    output logic                          uart_tx,
    output logic                          tx_busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int               BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        LAST_BYTE = 3'(FRAME_BYTES - 1);

    tx_state_t         state, state_next;
    logic [BAUD_W-1:0] baud_cnt, baud_next;
    logic [2:0]        bit_idx, bit_next;
    logic [2:0]        byte_idx, byte_next;
    resp_rec_t         frame, frame_next;
    logic              tx_next;
    logic              bit_done;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    resp_rec_t         fifo_head;

    uart_resp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (tx_data_ready),
        .wr_data (tx_data_in),
        .pop     (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign bit_done = (baud_cnt == BAUD_LAST);
    assign tx_busy  = (state != IDLE) || (fifo_count != '0);

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_idx;
        byte_next  = byte_idx;
        frame_next = frame;
        pop        = 1'b0;

        if (state != IDLE) begin
            baud_next = bit_done ? '0 : baud_cnt + BAUD_W'(1);
        end

        case (state)
            IDLE: begin
                baud_next = '0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    frame_next = fifo_head;
                    byte_next  = '0;
                    state_next = START;
                end
            end
            START: begin
                if (bit_done) begin
                    bit_next   = '0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx == 3'd7) state_next = STOP;
                    else                 bit_next   = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (byte_idx == LAST_BYTE) begin
                        state_next = IDLE;
                    end else begin
                        byte_next  = byte_idx + 3'd1;
                        state_next = START;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // The line is registered from the next-state view so the pin is
        // glitch-free yet changes on the same edge as the state.
        tx_next = line_level(state_next, frame_next, byte_next, bit_next, FRAME_HDR);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            frame    <= '0;
            uart_tx  <= 1'b1;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_idx  <= bit_next;
            byte_idx <= byte_next;
            frame    <= frame_next;
            uart_tx  <= tx_next;
            if (tx_data_ready && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_response_tx.sv
// Self-checking bench for uart_response_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_uart_response_tx;

    localparam int CPB       = 4;
    localparam int DEPTH     = 4;
    localparam int FRAME_CYC = 70 * CPB;

    typedef struct {
        string       name;
        logic [41:0] rec;
        logic [55:0] bytes;   // B0 in the top byte
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tx_data_ready = 1'b0;
    logic [41:0] tx_data_in = '0;
    logic        uart_tx;
    logic        tx_busy;
    logic        overflow;
    logic [2:0]  fifo_count;

    int n_assert = 0;
    int n_fail   = 0;

    vec_t vecs [4];
    int   burst_cnt [5];

    uart_response_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .FRAME_HDR    (8'hA5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .tx_data_in    (tx_data_in),
        .tx_data_ready (tx_data_ready),
        .uart_tx       (uart_tx),
        .tx_busy       (tx_busy),
        .overflow      (overflow),
        .fifo_count    (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [41:0] burst_rec(input int i);
        return {1'b0, 9'(i), 32'(i)};
    endfunction

    function automatic logic [55:0] burst_bytes(input int i);
        return {8'hA5, 8'h00, 8'(i), 24'h000000, 8'(i)};
    endfunction

    // Drive one pulse; returns at the negedge right after the sampling edge.
    task automatic send_pulse(input logic [41:0] rec);
        @(negedge clk);
        tx_data_in    = rec;
        tx_data_ready = 1'b1;
        @(negedge clk);
        tx_data_ready = 1'b0;
    endtask

    // Called at the negedge just before the pop edge. Captures the whole
    // frame one sample per cycle, checks the waveform bit-exactly, decodes
    // the bytes mid-bit, then checks the single idle cycle that follows.
    task automatic check_frame(input logic [55:0] exp, input string name);
        logic       line_s [FRAME_CYC];
        logic [7:0] bv;
        logic [7:0] dec;
        logic       eb;
        int         errs;
        int         first_bad;
        int         j, b, m;
        check({name, " idle before start"}, 64'(uart_tx), 64'd1);
        for (int k = 0; k < FRAME_CYC; k++) begin
            @(negedge clk);
            line_s[k] = uart_tx;
        end
        errs      = 0;
        first_bad = -1;
        for (int k = 0; k < FRAME_CYC; k++) begin
            j  = k / CPB;
            b  = j / 10;
            m  = j % 10;
            bv = exp[55-8*b -: 8];
            if (m == 0)      eb = 1'b0;
            else if (m == 9) eb = 1'b1;
            else             eb = bv[m-1];
            if (line_s[k] !== eb) begin
                errs++;
                if (first_bad < 0) first_bad = k;
            end
        end
        check($sformatf("%s waveform bad cycles (first %0d)", name, first_bad), 64'(errs), 64'd0);
        for (int bi = 0; bi < 7; bi++) begin
            for (int i = 0; i < 8; i++) begin
                dec[i] = line_s[(10*bi + 1 + i)*CPB + CPB/2];
            end
            check($sformatf("%s byte B%0d", name, bi), 64'(dec), 64'(exp[55-8*bi -: 8]));
        end
        @(negedge clk);
        check({name, " inter-frame idle"}, 64'(uart_tx), 64'd1);
    endtask

    initial begin
        vecs[0] = '{"deadbeef",  {1'b0, 9'h1FF, 32'hDEADBEEF}, 56'hA5_01_FF_DE_AD_BE_EF};
        vecs[1] = '{"memtype1",  {1'b1, 9'h003, 32'h00000001}, 56'hA5_80_03_00_00_00_01};
        vecs[2] = '{"addr_hi",   {1'b1, 9'h100, 32'h12345678}, 56'hA5_81_00_12_34_56_78};
        vecs[3] = '{"hi_zero",   {1'b0, 9'h0AA, 32'hFFFF0000}, 56'hA5_00_AA_FF_FF_00_00};
        burst_cnt = '{1, 1, 2, 3, 4};

        // 1. Reset and quiet idle
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset outputs", 64'({uart_tx, tx_busy, overflow, fifo_count}), 64'b100000);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check($sformatf("idle cycle %0d", i),
                  64'({uart_tx, tx_busy, overflow, fifo_count}), 64'b100000);
        end

        // 2/3. Single frames from the vector table
        for (int v = 0; v < 4; v++) begin
            send_pulse(vecs[v].rec);
            check({vecs[v].name, " count after push"}, 64'(fifo_count), 64'd1);
            check({vecs[v].name, " busy after push"},  64'(tx_busy),    64'd1);
            check_frame(vecs[v].bytes, vecs[v].name);
            check({vecs[v].name, " busy after frame"}, 64'(tx_busy),    64'd0);
            check({vecs[v].name, " count after frame"}, 64'(fifo_count), 64'd0);
        end

        // 4. Six back-to-back pulses: five frames, sixth dropped
        fork
            begin
                for (int i = 1; i <= 6; i++) begin
                    @(negedge clk);
                    if (i >= 2) check($sformatf("burst count after push %0d", i-1),
                                      64'(fifo_count), 64'(burst_cnt[i-2]));
                    if (i == 6) check("burst overflow before drop", 64'(overflow), 64'd0);
                    tx_data_in    = burst_rec(i);
                    tx_data_ready = 1'b1;
                end
                @(negedge clk);
                tx_data_ready = 1'b0;
                check("burst count after drop", 64'(fifo_count), 64'd4);
                check("burst overflow set",     64'(overflow),   64'd1);
            end
            begin
                repeat (2) @(negedge clk);
                check_frame(burst_bytes(1), "burst f1");
            end
        join
        for (int i = 2; i <= 5; i++) begin
            check_frame(burst_bytes(i), $sformatf("burst f%0d", i));
        end
        check("burst busy after drain",   64'(tx_busy),    64'd0);
        check("burst count after drain",  64'(fifo_count), 64'd0);
        check("burst overflow sticky",    64'(overflow),   64'd1);

        // 5. Push on a full FIFO in the same cycle as the pop
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("overflow cleared by reset", 64'(overflow), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tx_data_in    = burst_rec(16 + i);
            tx_data_ready = 1'b1;
        end
        @(negedge clk);
        tx_data_ready = 1'b0;
        check("full count", 64'(fifo_count), 64'd4);
        repeat (277) @(negedge clk);
        check("full count before pop edge", 64'(fifo_count), 64'd4);
        check("gap cycle line high",        64'(uart_tx),    64'd1);
        tx_data_in    = burst_rec(30);
        tx_data_ready = 1'b1;
        @(negedge clk);
        tx_data_ready = 1'b0;
        check("push+pop on full count",    64'(fifo_count), 64'd4);
        check("push+pop on full overflow", 64'(overflow),   64'd0);
        check("next frame start bit",      64'(uart_tx),    64'd0);

        // 6. Reset in the middle of byte B3 data bits
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tx_data_in    = {1'b0, 9'h055, 32'h00C3C3C3};
        tx_data_ready = 1'b1;
        @(negedge clk);
        tx_data_in    = burst_rec(7);
        @(negedge clk);
        tx_data_ready = 1'b0;
        repeat (129) @(negedge clk);
        check("mid-B3 line low",   64'(uart_tx),    64'd0);
        check("mid-B3 count",      64'(fifo_count), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("async reset line high", 64'(uart_tx),    64'd1);
        check("async reset count",     64'(fifo_count), 64'd0);
        check("async reset busy",      64'(tx_busy),    64'd0);
        @(negedge clk);
        reset = 1'b0;
        send_pulse(vecs[0].rec);
        check_frame(vecs[0].bytes, "after reset");
        check("after reset busy", 64'(tx_busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
